// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, sequencer state type and zero-register index for regfile_mp
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_ZERO   = 0;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/rf_rd_port.sv
// rtl/rf_rd_port.sv - one read port: zero/enable gating, priority write bypass, busy masking
module rf_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     active,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  input  logic [DATA_W-1:0]        arr_data,
  input  logic                     busy_bit,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rbusy
);

  logic              hit;
  logic [DATA_W-1:0] byp;
  logic              is_zero;

  // Ascending scan so the highest-index matching write port ends up selected.
  always_comb begin
    hit = 1'b0;
    byp = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (we[i] && (waddr[i*ADDR_W +: ADDR_W] == raddr)) begin
        hit = 1'b1;
        byp = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign is_zero = (ZERO_REG != 0) && (raddr == ADDR_W'(RF_ZERO));

  always_comb begin
    rdata = '0;
    if (active && re && !is_zero)
      rdata = hit ? byp : arr_data;
  end

  // A value being written this cycle resolves the pending producer.
  assign rbusy = active && re && busy_bit && !hit;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with clearing sequencer and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     bset,
  input  logic [ADDR_W-1:0]        bset_addr
);

  localparam int DEPTH = 1 << ADDR_W;

  rf_state_t         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              run;
  logic [NUM_WR-1:0] we_run;

  assign run       = (state_q == RF_RUN);
  assign init_done = run;
  assign we_run    = we & {NUM_WR{run}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RF_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_W'(DEPTH - 1))
        state_d = RF_RUN;
    end
  end

  // Array is never reset directly; the sequencer walks it back to zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == RF_INIT) begin
        mem[cnt_q] <= '0;
      end else begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (we_run[i] && !((ZERO_REG != 0) &&
              (waddr[i*ADDR_W +: ADDR_W] == ADDR_W'(RF_ZERO))))
            mem[waddr[i*ADDR_W +: ADDR_W]] <= wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Set is applied after the clears so a newer producer wins the same-cycle race.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else if (run) begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (we_run[i])
          busy[waddr[i*ADDR_W +: ADDR_W]] <= 1'b0;
      end
      if (bset && !((ZERO_REG != 0) && (bset_addr == ADDR_W'(RF_ZERO))))
        busy[bset_addr] <= 1'b1;
    end
  end

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    rf_rd_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .active  (run && !rst),
      .re      (re[j]),
      .raddr   (raddr[j*ADDR_W +: ADDR_W]),
      .arr_data(mem[raddr[j*ADDR_W +: ADDR_W]]),
      .busy_bit(busy[raddr[j*ADDR_W +: ADDR_W]]),
      .we      (we_run),
      .waddr   (waddr),
      .wdata   (wdata),
      .rdata   (rdata[j*DATA_W +: DATA_W]),
      .rbusy   (rbusy[j])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             init_done;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR-1:0]    re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rbusy;
  logic             bset;
  logic [AW-1:0]    bset_addr;

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk      (clk),
    .rst      (rst),
    .init_done(init_done),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re       (re),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .bset     (bset),
    .bset_addr(bset_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = '0; waddr = '0; wdata = '0;
    re = '0; raddr = '0;
    bset = 1'b0; bset_addr = '0;
  endtask

  task automatic rd(input int port, input logic [AW-1:0] a);
    re[port] = 1'b1;
    raddr[port*AW +: AW] = a;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[port] = 1'b1;
    waddr[port*AW +: AW] = a;
    wdata[port*DW +: DW] = d;
  endtask

  task automatic wait_init();
    cyc = 0;
    while (!init_done && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("reset_init_done", {31'd0, init_done}, 32'd0);
    rst = 1'b0;

    // Writes and busy-set held during the whole clearing sequence must be ignored.
    wr(0, 5'd4, 32'h1234);
    wr(1, 5'd6, 32'h5678);
    bset = 1'b1; bset_addr = 5'd4;
    rd(0, 5'd4);
    #1;
    chk("init_rdata_bypass_off", rdata[31:0], 32'h0);
    chk("init_rbusy", {31'd0, rbusy[0]}, 32'd0);
    wait_init();
    chk("init_edges", cyc, 32);
    idle();

    for (int i = 0; i < 32; i++) begin
      rd(0, 5'(i));
      rd(1, 5'(31 - i));
      #1;
      chk($sformatf("clear_rd0_x%0d", i), rdata[31:0], 32'h0);
      chk($sformatf("clear_rd1_x%0d", 31 - i), rdata[63:32], 32'h0);
      chk($sformatf("clear_rbusy_x%0d", i), {30'd0, rbusy}, 32'd0);
    end
    idle();

    // Bypass then array read.
    wr(0, 5'd5, 32'hDEADBEEF);
    rd(0, 5'd5);
    #1;
    chk("x5_bypass", rdata[31:0], 32'hDEADBEEF);
    tick();
    we = '0;
    #1;
    chk("x5_array", rdata[31:0], 32'hDEADBEEF);

    // Both write ports to x7: port 1 wins.
    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    rd(1, 5'd7);
    #1;
    chk("x7_bypass_prio", rdata[63:32], 32'h22);
    tick();
    we = '0;
    #1;
    chk("x7_array_prio", rdata[63:32], 32'h22);

    wr(0, 5'd0, 32'hFFFF);
    rd(0, 5'd0);
    #1;
    chk("x0_bypass_zero", rdata[31:0], 32'h0);
    tick();
    we = '0;
    #1;
    chk("x0_array_zero", rdata[31:0], 32'h0);
    idle();

    // Scoreboard.
    bset = 1'b1; bset_addr = 5'd9;
    tick();
    bset = 1'b0;
    rd(0, 5'd9);
    rd(1, 5'd9);
    #1;
    chk("x9_busy_set", {31'd0, rbusy[0]}, 32'd1);
    wr(1, 5'd9, 32'h5);
    #1;
    chk("x9_busy_masked", {30'd0, rbusy}, 32'd0);
    chk("x9_bypass", rdata[31:0], 32'h5);
    tick();
    we = '0;
    #1;
    chk("x9_busy_cleared", {31'd0, rbusy[0]}, 32'd0);
    chk("x9_array", rdata[31:0], 32'h5);
    bset = 1'b1; bset_addr = 5'd9;
    wr(0, 5'd9, 32'h6);
    tick();
    idle();
    rd(0, 5'd9);
    #1;
    chk("x9_set_wins", {31'd0, rbusy[0]}, 32'd1);
    chk("x9_data6", rdata[31:0], 32'h6);
    re = '0;
    #1;
    chk("re_off_rdata", rdata[31:0], 32'h0);
    chk("re_off_rbusy", {31'd0, rbusy[0]}, 32'd0);
    bset = 1'b1; bset_addr = 5'd0;
    tick();
    bset = 1'b0;
    rd(0, 5'd0);
    #1;
    chk("x0_never_busy", {31'd0, rbusy[0]}, 32'd0);
    idle();

    // Registers targeted during init stay clear.
    rd(0, 5'd4);
    rd(1, 5'd6);
    #1;
    chk("x4_after_init", rdata[31:0], 32'h0);
    chk("x6_after_init", rdata[63:32], 32'h0);
    chk("x4_not_busy", {31'd0, rbusy[0]}, 32'd0);
    idle();

    // Mid-run reset.
    wr(0, 5'd3, 32'hAA);
    tick();
    idle();
    rd(0, 5'd3);
    #1;
    chk("x3_loaded", rdata[31:0], 32'hAA);
    rst = 1'b1;
    #1;
    chk("rst_rdata_zero", rdata[31:0], 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_init_done_low", {31'd0, init_done}, 32'd0);
    wait_init();
    chk("reinit_edges", cyc, 32);
    rd(0, 5'd3);
    rd(1, 5'd9);
    #1;
    chk("x3_after_reinit", rdata[31:0], 32'h0);
    chk("x9_busy_after_reinit", {31'd0, rbusy[1]}, 32'd0);
    chk("x9_data_after_reinit", rdata[63:32], 32'h0);
    rd(0, 5'd5);
    #1;
    chk("x5_after_reinit", rdata[31:0], 32'h0);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
